// File: rtl/ntt_stage_router.sv
// ntt_stage_router: sequences NTT stages and permutes coefficient lanes into butterfly pairs
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start, log_n begin a transform of size 2^log_n (sampled only when idle)
//   busy         transform in progress, falls the cycle after done
//   done         one-cycle pulse aligned with the final out_valid
//   err          one-cycle pulse when start carries an unsupported log_n
//   in_valid, in_data, in_addr
//                one beat of 4C lanes plus its memory address tag
//   out_valid, out_data, out_addr, out_log_t, out_loop
//                routed beat, PIPE cycles after acceptance, with its stage distance and loop flag
module ntt_stage_router #(
   parameter int LOG_CORE_COUNT = 5,
   parameter int WIDTH          = 30,
   parameter int ADDR_WIDTH     = 9,
   parameter int LOG_N_MAX      = 12,
   parameter int PIPE           = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    start,
   input  logic [3:0]                              log_n,
   output logic                                    busy,
   output logic                                    done,
   output logic                                    err,
   input  logic                                    in_valid,
   input  logic [(4<<LOG_CORE_COUNT)*WIDTH-1:0]    in_data,
   input  logic [ADDR_WIDTH-1:0]                   in_addr,
   output logic                                    out_valid,
   output logic [(4<<LOG_CORE_COUNT)*WIDTH-1:0]    out_data,
   output logic [ADDR_WIDTH-1:0]                   out_addr,
   output logic [3:0]                              out_log_t,
   output logic                                    out_loop
);
   localparam int L     = LOG_CORE_COUNT + 2;
   localparam int LANES = 4 << LOG_CORE_COUNT;
   localparam int DW    = LANES * WIDTH;
   localparam int CW    = (LOG_N_MAX > L) ? LOG_N_MAX - L + 1 : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nx;
   logic [3:0]      d, d_nx, shift, shift_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            busy_r, busy_nx, err_r, err_nx;
   logic            legal, take_start, accept, last_beat, final_beat;
   logic [DW-1:0]   routed;

   logic [PIPE-1:0]       v_p, done_p, loop_p;
   logic [DW-1:0]         data_p [PIPE];
   logic [ADDR_WIDTH-1:0] addr_p [PIPE];
   logic [3:0]            logt_p [PIPE];

   always_comb begin
      legal      = log_n >= 4'(L) && log_n <= 4'(LOG_N_MAX);
      // busy_r covers the drain after the sequencer has returned to IDLE
      take_start = state == IDLE && !busy_r && start;
      accept     = state == RUN && in_valid;
      last_beat  = cnt == (CW'(1) << shift) - CW'(1);
      final_beat = accept && last_beat && d == 4'd0;
      state_nx   = state;
      d_nx       = d;
      shift_nx   = shift;
      cnt_nx     = cnt;
      err_nx     = take_start && !legal;
      busy_nx    = (take_start && legal) ? 1'b1 : (done ? 1'b0 : busy_r);
      if (take_start && legal) begin
         state_nx = RUN;
         d_nx     = log_n - 4'd1;
         shift_nx = log_n - 4'(L);
         cnt_nx   = '0;
      end else if (accept) begin
         cnt_nx = last_beat ? '0 : cnt + CW'(1);
         if (last_beat) begin
            state_nx = (d == 4'd0) ? IDLE : RUN;
            d_nx     = (d == 4'd0) ? d : d - 4'd1;
         end
      end
   end

   // Cross mode swaps lane-index bits 0 and d; d = 0 and loop mode (d >= L) are identity.
   always_comb begin
      routed = in_data;
      for (int k = 1; k < L; k++)
         if (d == 4'(k))
            for (int p = 0; p < LANES; p++)
               routed[p*WIDTH +: WIDTH] =
                  in_data[((p & ~(1 | (1 << k))) | ((p >> k) & 1) | ((p & 1) << k))*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         d      <= '0;
         shift  <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         err_r  <= 1'b0;
      end else begin
         state  <= state_nx;
         d      <= d_nx;
         shift  <= shift_nx;
         cnt    <= cnt_nx;
         busy_r <= busy_nx;
         err_r  <= err_nx;
      end
   end

   // Payload registers only load behind a valid beat so idle outputs stay quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_p    <= '0;
         done_p <= '0;
         loop_p <= '0;
         for (int i = 0; i < PIPE; i++) begin
            data_p[i] <= '0;
            addr_p[i] <= '0;
            logt_p[i] <= '0;
         end
      end else begin
         v_p[0]    <= accept;
         done_p[0] <= final_beat;
         if (accept) begin
            data_p[0] <= routed;
            addr_p[0] <= in_addr;
            logt_p[0] <= d;
            loop_p[0] <= d >= 4'(L);
         end
         for (int i = 1; i < PIPE; i++) begin
            v_p[i]    <= v_p[i-1];
            done_p[i] <= done_p[i-1];
            if (v_p[i-1]) begin
               data_p[i] <= data_p[i-1];
               addr_p[i] <= addr_p[i-1];
               logt_p[i] <= logt_p[i-1];
               loop_p[i] <= loop_p[i-1];
            end
         end
      end
   end

   assign busy      = busy_r;
   assign err       = err_r;
   assign done      = done_p[PIPE-1];
   assign out_valid = v_p[PIPE-1];
   assign out_data  = data_p[PIPE-1];
   assign out_addr  = addr_p[PIPE-1];
   assign out_log_t = logt_p[PIPE-1];
   assign out_loop  = loop_p[PIPE-1];
endmodule

// File: tb/tb_ntt_stage_router.sv
// tb_ntt_stage_router: directed checks of stage sequencing, lane routing, latency and control pulses
module tb_ntt_stage_router;
   localparam int N = 128;
   localparam int W = 30;
   localparam int A = 9;
   localparam int PIPE = 2;

   logic           clk = 0;
   logic           rst_n = 1;
   logic           start = 0;
   logic [3:0]     log_n = 0;
   logic           in_valid = 0;
   logic [N*W-1:0] in_data = '0;
   logic [A-1:0]   in_addr = '0;
   logic           busy, done, err, out_valid, out_loop;
   logic [N*W-1:0] out_data;
   logic [A-1:0]   out_addr;
   logic [3:0]     out_log_t;

   ntt_stage_router dut (
      .clk(clk), .rst_n(rst_n), .start(start), .log_n(log_n),
      .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
      .out_log_t(out_log_t), .out_loop(out_loop)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int n_ov = 0, n_done = 0, n_err = 0;
   int q_d[$], q_c[$], q_a[$], q_b[$], q_l[$];
   int lanes[12] = '{0, 1, 2, 3, 4, 5, 8, 16, 32, 64, 65, 127};
   int hand1[8] = '{0, 2, 1, 3, 4, 6, 5, 7};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int swp(input int p, input int d);
      if (d >= 7) return p;
      return (p & ~(1 | (1 << d))) | ((p >> d) & 1) | ((p & 1) << d);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   logic pd = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (pd) chk("busy_fall", busy, 0);
         pd = done;
         if (err) n_err++;
         if (done) n_done++;
         if (done && !out_valid) chk("done_alone", 1, 0);
         if (out_valid) begin
            n_ov++;
            if (q_d.size() == 0) chk("unexpected_ov", 1, 0);
            else begin
               int ed, ec, ea, eb, el;
               ed = q_d.pop_front(); ec = q_c.pop_front(); ea = q_a.pop_front();
               eb = q_b.pop_front(); el = q_l.pop_front();
               chk("latency", cyc - ec, PIPE);
               chk("log_t", out_log_t, ed);
               chk("loop", out_loop, ed >= 7);
               chk("addr", out_addr, ea);
               chk("done", done, el);
               chk("busy_ov", busy, 1);
               foreach (lanes[j])
                  chk($sformatf("lane%0d_d%0d", lanes[j], ed), out_data[lanes[j]*W +: W], eb + swp(lanes[j], ed));
               if (eb == 0 && ed == 1)
                  foreach (hand1[j]) chk($sformatf("d1_lane%0d", j), out_data[j*W +: W], hand1[j]);
               if (eb == 0 && ed == 6) begin
                  chk("d6_lane1", out_data[1*W +: W], 64);
                  chk("d6_lane64", out_data[64*W +: W], 1);
               end
            end
         end
      end
   end

   task automatic fill(input int base);
      for (int g = 0; g < N; g++) in_data[g*W +: W] = W'(base + g);
   endtask

   task automatic send_start(input logic [3:0] ln);
      @(negedge clk);
      start = 1; log_n = ln;
      @(negedge clk);
      start = 0;
   endtask

   task automatic run(input int ln, input int base, input int addr0, input int step,
                      input int gap, input int mid_start, input int abort_at);
      int beats, idx;
      beats = 1 << (ln - 7);
      idx = 0;
      fill(base);
      for (int s = ln - 1; s >= 0; s--)
         for (int b = 0; b < beats; b++) begin
            @(negedge clk);
            in_valid = 1;
            in_addr  = A'(addr0 + step * idx);
            start    = (idx == mid_start);
            if (idx == mid_start) log_n = 4'd7;
            q_d.push_back(s); q_c.push_back(cyc); q_a.push_back(int'(in_addr));
            q_b.push_back(base); q_l.push_back(s == 0 && b == beats - 1);
            idx++;
            if (idx == abort_at) return;
            if (gap != 0) begin
               @(negedge clk);
               in_valid = 0; start = 0;
            end
         end
      @(negedge clk);
      in_valid = 0; start = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q_d.size() > 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("drain", q_d.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ov0, dn0;
      #1 rst_n = 0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_loop", out_loop, 0);
      chk("rst_data", out_data == '0, 1);
      chk("rst_addr", out_addr, 0);
      chk("rst_logt", out_log_t, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // log_n=11 full run, lane g = g, fixed address
      ov0 = n_ov; dn0 = n_done;
      chk("busy_pre", busy, 0);
      send_start(4'd11);
      chk("busy_rise", busy, 1);
      run(11, 0, 10, 0, 0, -1, -1);
      drain();
      chk("t1_ov_count", n_ov - ov0, 176);
      chk("t1_done_count", n_done - dn0, 1);
      chk("t1_busy_end", busy, 0);

      // log_n=7: one beat per stage
      ov0 = n_ov; dn0 = n_done;
      send_start(4'd7);
      run(7, 300, 3, 1, 0, -1, -1);
      drain();
      chk("t3_ov_count", n_ov - ov0, 7);
      chk("t3_done_count", n_done - dn0, 1);

      // illegal sizes
      ov0 = n_ov;
      send_start(4'd6);
      chk("err6", err, 1);
      chk("busy6", busy, 0);
      @(negedge clk);
      chk("err6_clear", err, 0);
      send_start(4'd13);
      chk("err13", err, 1);
      chk("busy13", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1;
      end
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      chk("idle_no_ov", n_ov - ov0, 0);
      chk("err_count", n_err, 2);

      // log_n=8 with gaps and a start mid-run that must be ignored
      ov0 = n_ov; dn0 = n_done;
      send_start(4'd8);
      run(8, 1000, 100, 1, 1, 5, -1);
      drain();
      chk("t5_ov_count", n_ov - ov0, 16);
      chk("t5_done_count", n_done - dn0, 1);
      chk("t5_no_err", n_err, 2);

      // abort after beat 5 of a log_n=11 run
      ov0 = n_ov; dn0 = n_done;
      send_start(4'd11);
      run(11, 2000, 50, 1, 0, -1, 5);
      @(posedge clk);
      #1;
      rst_n = 0; in_valid = 0;
      q_d.delete(); q_c.delete(); q_a.delete(); q_b.delete(); q_l.delete();
      #1;
      chk("abort_ov", out_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_data", out_data == '0, 1);
      chk("abort_addr", out_addr, 0);
      chk("abort_logt", out_log_t, 0);
      @(posedge clk);
      #1 rst_n = 1;
      repeat (5) @(negedge clk);
      chk("abort_ov_count", n_ov - ov0, 3);
      chk("abort_no_done", n_done - dn0, 0);
      chk("abort_idle", busy, 0);
      ov0 = n_ov; dn0 = n_done;
      send_start(4'd7);
      run(7, 0, 7, 2, 0, -1, -1);
      drain();
      chk("t6_ov_count", n_ov - ov0, 7);
      chk("t6_done_count", n_done - dn0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ntt_stage_router.md
Name: ntt_stage_router

Overview:
- Parametrised, pipelined successor to the fixed-size NTT router.
- Sits between the butterfly core array and the coefficient memories.
- Takes one beat of 4 coefficients per core and permutes lanes so each output pair is the butterfly pair for the stage distance.
- An internal stage sequencer walks log_t from log_n-1 down to 0, so the top level only issues start and streams beats.

Parameters:
LOG_CORE_COUNT, 5, log2 of core count C; lane count is 4C, lane-index bits L = LOG_CORE_COUNT+2
WIDTH, 30, coefficient width in bits
ADDR_WIDTH, 9, coefficient-memory address width
LOG_N_MAX, 12, largest supported log2 transform size (must be ≤ L+ADDR_WIDTH)
PIPE, 2, output register stages (1..3)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a transform; sampled only in IDLE
log_n  in  4  log2 transform size, sampled with start
busy  out  1  transform in progress
done  out  1  one-cycle pulse aligned with the final out_valid
err  out  1  one-cycle pulse on an illegal log_n at start
in_valid  in  1  beat present on in_data/in_addr
in_data  in  4C*WIDTH  lane g at [g*WIDTH +: WIDTH]; core i drives lanes 4i..4i+3
in_addr  in  ADDR_WIDTH  address tag of the beat
out_valid  out  1  routed beat present
out_data  out  4C*WIDTH  lane p at [p*WIDTH +: WIDTH]; core i pair k = {lane 4i+2k+1, lane 4i+2k}
out_addr  out  ADDR_WIDTH  address tag, passed through
out_log_t  out  4  distance exponent d used for the beat
out_loop  out  1  1 = loop mode (identity, partner is in memory)

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; all counters cleared. Outputs busy, done, err, out_valid, out_loop = 0; out_data, out_addr, out_log_t = 0. Pipeline contents are discarded.
- FSM states: IDLE, RUN.
  - IDLE to RUN on start with L ≤ log_n ≤ LOG_N_MAX. Load d = log_n-1 and beat_cnt = 0. busy rises the next cycle.
  - start with an illegal log_n: err pulses the next cycle and the FSM stays in IDLE.
- Beats:
  - BEATS = 2^(log_n-L) per stage.
  - In RUN, each in_valid beat is accepted and increments beat_cnt.
  - On beat_cnt = BEATS-1: wrap beat_cnt to 0 and decrement d.
  - If d was already 0 on that beat, it is the last beat; the FSM returns to IDLE the following cycle.
- Routing per accepted beat, using the current d:
  - d ≥ L: loop mode, out lane p = in lane p, out_loop = 1.
  - d < L: cross mode, out lane p = in lane q, where q is p with bits 0 and d swapped (d=0 is the identity). out_loop = 0.
- Address is never modified.
- Latency: out_valid, out_data, out_addr, out_log_t and out_loop appear exactly PIPE cycles after the accepted in_valid. There is no backpressure.
- done is pipelined with the last beat and pulses in the same cycle as its out_valid. busy falls in the cycle after done.
- Ignored inputs:
  - in_valid in IDLE is ignored: no out_valid and no counting.
  - start while busy is ignored; no restart and no err.
- Reset asserted mid-transform aborts immediately. No further out_valid or done. A new start after release behaves normally.
- Gaps in in_valid are allowed; counting advances only on valid beats.

Test Plan:
1. Defaults (C=32, L=7, PIPE=2), log_n=11, in lane g = g every beat. Expect 11 stages × 16 = 176 out_valid beats. The first 64 beats have out_log_t = 10, 9, 8, 7 with out_loop=1 and out = in. done pulses with beat 176; busy is high for exactly the run.
2. Same run, beats with d=1: out lanes 0..3 = 0, 2, 1, 3, and out lane 4i+k follows the same pattern for every i. Beats with d=6: out lane 1 = 64 and out lane 64 = 1. Beats with d=0: out = in. in_addr = 10 returns out_addr = 10 every beat.
3. log_n=7 (BEATS=1): 7 beats with out_log_t = 6..0. done pulses with the 7th out_valid, 2 cycles after its input.
4. start with log_n=6, then with log_n=13: err pulses once each, busy stays 0, and in_valid beats produce no out_valid.
5. in_valid toggling every other cycle during a log_n=8 run: the stage advances every 2 accepted beats (not cycles). A second start mid-run is ignored. Total out_valid count is 16.
6. rst_n low for 1 cycle after beat 5 of a log_n=11 run: all outputs go to 0 immediately with no done. A new start with log_n=7 then completes normally.
